rsa_modexp_responder: RTL and testbench
=======================================

// Module: rsa_modexp_responder
// PURPOSE
//  Modular-exponentiation engine: result = base^exponent mod modulus. Responder end of the start/finish handshake
//  that RSA control sequencing drives (pulse start, poll finish), e.g. msg^e mod n or msg^d mod n.
//  Sits behind the key/inverter stage; result is valid whenever finish is high.
// PARAMETERS
//  WIDTH  128  prime width; every operand and the result are 2*WIDTH bits
// PORTS
//  clk       in   1        single clock, all state updates on rising edge
//  reset_n   in   1        asynchronous, active-low reset
//  start     in   1        request; sampled only in IDLE/DONE, one-cycle pulse is sufficient
//  base      in   2*WIDTH  message/ciphertext; precondition base < modulus
//  exponent  in   2*WIDTH  public or private exponent
//  modulus   in   2*WIDTH  n = p*q
//  result    out  2*WIDTH  base^exponent mod modulus
//  busy      out  1        high from the cycle after start is accepted until finish rises
//  finish    out  1        level; high in DONE, held until the next accepted start
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, result=0, busy=0, finish=0, all datapath registers 0.
//  - Accept: start=1 in IDLE or DONE -> base/exponent/modulus latched next edge, finish->0, busy->1, state LOAD.
//    start while busy is ignored. Inputs may change freely after the accept edge.
//  - LOAD: R=1, B=base, E=exponent, bit count k=0.
//    If modulus<=1: result=0, go directly to DONE (finish on 2nd edge after accept).
//  - Right-to-left square-and-multiply over k = 0..2*WIDTH-1:
//    MUL_R: R = R*B mod N if E[0]=1; with E[0]=0 the multiply still runs, product discarded (constant time).
//    MUL_B: B = B*B mod N.
//    NEXT:  E >>= 1, k++; k==2*WIDTH -> DONE, else -> MUL_R.
//  - DONE: result=R, busy=0, finish=1; stays in DONE until start.
//  - Each modmul: 2*WIDTH+1 cycles, MSB-first interleaved:
//    P=0; per multiplier bit: P=2P-(2P>=N?N:0); if bit set, P=P+b-(P+b>=N?N:0).
//    Internal sums are 2*WIDTH+1 bits wide; no truncation before the compare.
//  - Latency (macro off): exactly 2 + 2*WIDTH*(2*(2*WIDTH+1)+1) cycles from accept edge to finish, for any data.
//  - exponent=0 -> result=1 (modulus>1). base=0, exponent>0 -> result=0.
//  - reset_n low mid-operation: abort immediately to reset state; no partial result visible.
// CONFIGURATION
//  RSA_MODEXP_EARLY_EXIT_EN
//    defined:   NEXT goes to DONE once remaining E==0. MUL_R is skipped (no dummy multiply) when E[0]=0.
//               Latency becomes data-dependent.
//    undefined: fixed-latency constant-time schedule above; the only mode for private-exponent use.
// STRUCTURE
//  - Package rsa_pkg: state enum (IDLE, LOAD, MUL_R, MUL_B, NEXT, DONE), localparam OPW=2*WIDTH,
//    modmul cycle-count constant.
//  - Sub-module rsa_modmul:
//    ports clk, reset_n, go, a, b, n, p, done.
//    Bit-serial interleaved modular multiplier, one instance, shared by MUL_R and MUL_B
//    (operand mux in the parent).
//  - Parent holds the FSM, R/B/E registers, bit counter and the handshake outputs.
// TESTING (WIDTH=8, 16-bit operands unless noted)
//  1. base=4, exp=13, mod=497 -> finish with result=445; busy falls the same edge finish rises;
//     latency = 2+16*(2*17+1)=562 cycles with macro off.
//  2. RSA round trip, mod=3233: base=65, exp=17 -> 2790; then base=2790, exp=2753 -> 65.
//  3. Boundaries: exp=0, base=3, mod=7 -> 1; mod=1 -> 0 two edges after accept;
//     base=0, exp=5, mod=13 -> 0; base=5, exp=3, mod=13 -> 8.
//  4. Handshake: second start pulse mid-run with different operands -> ignored, result of first request unchanged;
//     start while finish=1 -> finish drops next edge, new run begins.
//  5. Reset: reset_n low at cycle 100 of case 1 -> busy=finish=result=0 asynchronously;
//     rerun -> 445 with full latency.
//  6. WIDTH=128 with p=113680897410347, q=7999808077935876437321, small e=65537:
//     encrypt then decrypt with matching d -> original msg; with RSA_MODEXP_EARLY_EXIT_EN,
//     same results and encrypt latency strictly shorter.

Source files
------------

// File: rtl/rsa_pkg.sv
// ============================================================================
// Module : rsa_pkg
// Brief  : Shared FSM state type and sizing helpers for the modexp responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL_R = 3'd2,
        MUL_B = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEF_WIDTH = 128;
    localparam int OPW       = 2 * DEF_WIDTH;

    function automatic int opw_of(input int width);
        return 2 * width;
    endfunction

    // One cycle per multiplier bit plus the cycle in which the result is handed over.
    function automatic int mm_cycles(input int opw);
        return opw + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rsa_modmul.sv
// ============================================================================
// Module : rsa_modmul
// Brief  : Bit-serial MSB-first interleaved modular multiplier, p = a*b mod n.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int BITS = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            go,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] p,
    output logic            done
);

    localparam int CW   = $clog2(BITS + 1);
    localparam int LAST = mm_cycles(BITS) - 1;

    logic [BITS-1:0] r_a, r_b, r_n, r_p;
    logic [CW-1:0]   r_cnt;
    logic            r_act;

    logic [BITS-1:0] w_p_in, w_b, w_n, w_step;
    logic            w_bit;
    logic [BITS:0]   w_dbl, w_red, w_sum, w_n_ext, w_res;

    // The go cycle already consumes the first multiplier bit straight from the inputs.
    always_comb begin
        w_p_in  = go ? '0 : r_p;
        w_bit   = go ? a[BITS-1] : r_a[BITS-1];
        w_b     = go ? b : r_b;
        w_n     = go ? n : r_n;
        w_n_ext = {1'b0, w_n};
        w_dbl   = {w_p_in, 1'b0};
        w_red   = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
        w_sum   = w_red + {1'b0, w_b};
        w_res   = w_red;
        if (w_bit) begin
            w_res = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
        end
        w_step  = w_res[BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_n   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_act <= 1'b0;
        end else if (go) begin
            r_a   <= a << 1;
            r_b   <= b;
            r_n   <= n;
            r_p   <= w_step;
            r_cnt <= CW'(1);
            r_act <= 1'b1;
        end else if (r_act) begin
            if (r_cnt == CW'(LAST)) begin
                r_act <= 1'b0;
            end else begin
                r_p   <= w_step;
                r_a   <= r_a << 1;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign p    = r_p;
    assign done = r_act && (r_cnt == CW'(LAST));

endmodule

`default_nettype wire

// File: rtl/rsa_modexp_responder.sv
// ============================================================================
// Module : rsa_modexp_responder
// Brief  : Right-to-left square-and-multiply modexp behind a start/finish handshake.
//          Option macro RSA_MODEXP_EARLY_EXIT_EN enables data-dependent early exit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rsa_modexp_responder
    import rsa_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   base,
    input  logic [2*WIDTH-1:0]   exponent,
    input  logic [2*WIDTH-1:0]   modulus,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 finish
);

    localparam int OW = opw_of(WIDTH);
    localparam int KW = $clog2(OW + 1);

    state_t         r_state, w_next;
    logic [OW-1:0]  r_r, r_b, r_e, r_n, r_result;
    logic [KW-1:0]  r_k;
    logic           r_go;

    logic [OW-1:0]  w_mm_a, w_mm_p, w_e_shr;
    logic           w_mm_done, w_go, w_n_small, w_last;

    assign w_mm_a    = (r_state == MUL_R) ? r_r : r_b;
    assign w_e_shr   = r_e >> 1;
    assign w_n_small = (r_n[OW-1:1] == '0);
    assign w_last    = (r_k == KW'(OW - 1));

    rsa_modmul #(.BITS(OW)) u_modmul (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (r_go),
        .a       (w_mm_a),
        .b       (r_b),
        .n       (r_n),
        .p       (w_mm_p),
        .done    (w_mm_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != IDLE) && (r_state != DONE);
        finish = (r_state == DONE);
        result = r_result;
        case (r_state)
            IDLE, DONE: if (start) w_next = LOAD;
            LOAD: begin
                if (w_n_small) w_next = DONE;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                else if (r_e == '0) w_next = DONE;
                else if (!r_e[0])   w_next = MUL_B;
`endif
                else w_next = MUL_R;
            end
            MUL_R: if (w_mm_done) w_next = MUL_B;
            MUL_B: if (w_mm_done) w_next = NEXT;
            NEXT: begin
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                if (w_last || (w_e_shr == '0)) w_next = DONE;
                else if (w_e_shr[0])           w_next = MUL_R;
                else                           w_next = MUL_B;
`else
                if (w_last) w_next = DONE;
                else        w_next = MUL_R;
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    // A multiplier launch is requested on every entry into a multiply state.
    assign w_go = (w_next != r_state) && ((w_next == MUL_R) || (w_next == MUL_B));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_r      <= '0;
            r_b      <= '0;
            r_e      <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_go     <= 1'b0;
            r_result <= '0;
        end else begin
            r_go <= w_go;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_b <= base;
                        r_e <= exponent;
                        r_n <= modulus;
                    end
                end
                LOAD: begin
                    r_r <= OW'(1);
                    r_k <= '0;
                    if (w_next == DONE) r_result <= w_n_small ? '0 : OW'(1);
                end
                // Product is discarded when the exponent bit is clear to keep timing flat.
                MUL_R: if (w_mm_done && r_e[0]) r_r <= w_mm_p;
                MUL_B: if (w_mm_done) r_b <= w_mm_p;
                NEXT: begin
                    r_e <= w_e_shr;
                    r_k <= r_k + 1'b1;
                    if (w_next == DONE) r_result <= r_r;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_responder.sv
// ============================================================================
// Module : tb_rsa_modexp_responder
// Brief  : Directed-vector bench for rsa_modexp_responder at WIDTH=8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rsa_modexp_responder;

    localparam int WIDTH = 8;
    localparam int OW    = 2 * WIDTH;
    localparam int LAT   = 2 + OW * (2 * (OW + 1) + 1);
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [OW-1:0] base = '0;
    logic [OW-1:0] exponent = '0;
    logic [OW-1:0] modulus = '0;
    logic [OW-1:0] result;
    logic          busy;
    logic          finish;

    int n_total = 0;
    int n_bad   = 0;

    rsa_modexp_responder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .result   (result),
        .busy     (busy),
        .finish   (finish)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Returns just after the accept edge; cyc counts that edge as 1.
    task automatic launch(input logic [OW-1:0] b, input logic [OW-1:0] e,
                          input logic [OW-1:0] m, output int cyc);
        @(negedge clk);
        base     = b;
        exponent = e;
        modulus  = m;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        base     = OW'($urandom);
        exponent = OW'($urandom);
        modulus  = OW'($urandom);
        cyc      = 1;
    endtask

    task automatic wait_finish(inout int cyc, output logic ok);
        ok = 1'b1;
        while (!finish && cyc < LIMIT) begin
            if (!busy) ok = 1'b0;
            @(posedge clk);
            cyc++;
            #1;
        end
        if (busy) ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [OW-1:0] b, input logic [OW-1:0] e,
                          input logic [OW-1:0] m, input logic [OW-1:0] exp_res, input int exp_lat);
        int   cyc;
        logic ok;
        launch(b, e, m, cyc);
        wait_finish(cyc, ok);
        check_eq({tag, " finish"}, 32'(finish), 32'd1);
        check_eq({tag, " result"}, 32'(result), 32'(exp_res));
        check_eq({tag, " busy"},   32'(ok),     32'd1);
`ifndef RSA_MODEXP_EARLY_EXIT_EN
        if (exp_lat > 0) check_eq({tag, " latency"}, 32'(cyc), 32'(exp_lat));
`endif
    endtask

    initial begin
        int   cyc;
        logic ok;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset result", 32'(result), 32'd0);
        check_eq("reset busy",   32'(busy),   32'd0);
        check_eq("reset finish", 32'(finish), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("t1 4^13%497",      16'd4,    16'd13,   16'd497,  16'd445,  LAT);
        run_op("t2 enc",           16'd65,   16'd17,   16'd3233, 16'd2790, LAT);
        run_op("t2 dec",           16'd2790, 16'd2753, 16'd3233, 16'd65,   LAT);
        run_op("t3 exp0",          16'd3,    16'd0,    16'd7,    16'd1,    0);
        run_op("t3 mod1",          16'd0,    16'd9,    16'd1,    16'd0,    2);
        run_op("t3 base0",         16'd0,    16'd5,    16'd13,   16'd0,    0);
        run_op("t3 5^3%13",        16'd5,    16'd3,    16'd13,   16'd8,    0);

        // Second start mid-run must be ignored.
        launch(16'd4, 16'd13, 16'd497, cyc);
        repeat (49) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        base     = 16'd65;
        exponent = 16'd17;
        modulus  = 16'd3233;
        start    = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        start = 1'b0;
        wait_finish(cyc, ok);
        check_eq("t4 ignore result", 32'(result), 32'd445);
        check_eq("t4 ignore busy",   32'(ok),     32'd1);
`ifndef RSA_MODEXP_EARLY_EXIT_EN
        check_eq("t4 ignore latency", 32'(cyc), 32'(LAT));
`endif

        // Restart from DONE: finish drops at the accept edge.
        launch(16'd5, 16'd3, 16'd13, cyc);
        check_eq("t4 restart finish", 32'(finish), 32'd0);
        check_eq("t4 restart busy",   32'(busy),   32'd1);
        wait_finish(cyc, ok);
        check_eq("t4 restart result", 32'(result), 32'd8);

        // Asynchronous reset in the middle of a run.
        launch(16'd4, 16'd13, 16'd497, cyc);
        repeat (98) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t5 async busy",   32'(busy),   32'd0);
        check_eq("t5 async finish", 32'(finish), 32'd0);
        check_eq("t5 async result", 32'(result), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("t5 rerun",         16'd4,    16'd13,   16'd497,  16'd445,  LAT);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
